// File: rtl/mc_pkg.sv
// Shared constants, FSM state type and pointer-width helper for the MC frame scheduler.
package mc_pkg;

    localparam int unsigned MC_N  = 256;
    localparam int unsigned MC_DW = 16;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        WAIT   = 2'd1,
        LAUNCH = 2'd2
    } mc_state_e;

    // Bits needed to address v entries (minimum 1).
    function automatic int unsigned mc_log2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) r = i + 1;
        end
        if (r == 0) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/mc_frame_buf.sv
// One-frame sample store: synchronous write port, synchronous read port with a
// registered output that returns zero whenever no read is issued.
module mc_frame_buf
    import mc_pkg::*;
#(
    parameter int unsigned DEPTH = MC_N,
    parameter int unsigned W     = 3 * MC_DW,
    parameter int unsigned AW    = mc_log2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Zero when idle so the downstream sample bus is quiet between frames.
    always_ff @(posedge clk) begin
        if (rst)        rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];
        else            rd_data <= '0;
    end

endmodule

// File: rtl/mc_frame_scheduler.sv
// Store-and-forward frame sequencer feeding the MC pipeline with contiguous frames.
// Optional idle watchdog (err_timeout port) enabled by defining MC_SCHED_WATCHDOG_EN.
module mc_frame_scheduler
    import mc_pkg::*;
#(
    parameter int unsigned N            = MC_N,
    parameter int unsigned DW           = MC_DW,
    parameter int unsigned MAX_INFLIGHT = 2
`ifdef MC_SCHED_WATCHDOG_EN
    ,
    parameter int unsigned TIMEOUT      = 4096
`endif
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_x_real,
    input  logic [DW-1:0] s_delta_real,
    input  logic [DW-1:0] s_delta_img,
    output logic          mc_in_valid,
    output logic [DW-1:0] mc_x_real,
    output logic [DW-1:0] mc_delta_real,
    output logic [DW-1:0] mc_delta_img,
    input  logic          mc_out_valid,
    output logic          frame_done,
    output logic [1:0]    inflight,
    output logic [15:0]   frames_done,
    output logic          err_spurious
`ifdef MC_SCHED_WATCHDOG_EN
    ,
    output logic          err_timeout
`endif
);

    localparam int unsigned AW     = mc_log2(N);
    localparam int unsigned BW     = 3 * DW;
    localparam logic [1:0]  MAX_IF = 2'(MAX_INFLIGHT);

    mc_state_e     state;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] out_cnt;
    logic [BW-1:0] rd_data;
    logic          accept;
    logic          rd_en;
    logic          launch_beat0;
    logic          ret_beat;
    logic          ret_last;
    logic [1:0]    inflight_dec;
    logic          wd_fire;

    always_comb begin
        accept       = (state == FILL) && s_valid && s_ready;
        rd_en        = (state == LAUNCH);
        launch_beat0 = rd_en && (rd_ptr == '0);
        ret_beat     = mc_out_valid && (inflight != 2'd0);
        ret_last     = ret_beat && (out_cnt == AW'(N - 1));
        inflight_dec = inflight - 2'(ret_last);
    end

    mc_frame_buf #(
        .DEPTH (N),
        .W     (BW),
        .AW    (AW)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (accept),
        .wr_addr (wr_ptr),
        .wr_data ({s_x_real, s_delta_real, s_delta_img}),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    assign {mc_x_real, mc_delta_real, mc_delta_img} = rd_data;

`ifdef MC_SCHED_WATCHDOG_EN
    logic [15:0] idle_cnt;

    assign wd_fire = (inflight != 2'd0) && !mc_out_valid && (idle_cnt == 16'(TIMEOUT - 1));

    // Idle counter only runs while frames are owed back by MC.
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt    <= '0;
            err_timeout <= 1'b0;
        end else if ((inflight == 2'd0) || mc_out_valid) begin
            idle_cnt    <= '0;
        end else if (wd_fire) begin
            idle_cnt    <= '0;
            err_timeout <= 1'b1;
        end else begin
            idle_cnt    <= idle_cnt + 16'd1;
        end
    end
`else
    assign wd_fire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= FILL;
            s_ready      <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            out_cnt      <= '0;
            inflight     <= 2'd0;
            mc_in_valid  <= 1'b0;
            frame_done   <= 1'b0;
            frames_done  <= 16'd0;
            err_spurious <= 1'b0;
        end else begin
            mc_in_valid <= rd_en;
            frame_done  <= ret_last;
            if (ret_last) frames_done <= frames_done + 16'd1;
            if (mc_out_valid && (inflight == 2'd0)) err_spurious <= 1'b1;
            // N is a power of two, so the return counter wraps on its own.
            if (ret_beat) out_cnt <= out_cnt + AW'(1);

            if (launch_beat0 && !ret_last)      inflight <= inflight + 2'd1;
            else if (!launch_beat0 && ret_last) inflight <= inflight - 2'd1;

            case (state)
                FILL: begin
                    s_ready <= 1'b1;
                    if (accept) begin
                        wr_ptr <= wr_ptr + AW'(1);
                        if (wr_ptr == AW'(N - 1)) begin
                            state   <= WAIT;
                            s_ready <= 1'b0;
                        end
                    end
                end
                WAIT: begin
                    s_ready <= 1'b0;
                    if (inflight_dec < MAX_IF) begin
                        state  <= LAUNCH;
                        rd_ptr <= '0;
                    end
                end
                LAUNCH: begin
                    s_ready <= 1'b0;
                    rd_ptr  <= rd_ptr + AW'(1);
                    if (rd_ptr == AW'(N - 1)) begin
                        state   <= FILL;
                        s_ready <= 1'b1;
                    end
                end
                default: begin
                    state   <= FILL;
                    s_ready <= 1'b0;
                end
            endcase

            // Watchdog abandons all outstanding frames; a frame parked in WAIT is dropped.
            if (wd_fire) begin
                inflight <= 2'd0;
                out_cnt  <= '0;
                if (state == WAIT) begin
                    state   <= FILL;
                    s_ready <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/mc_frame_scheduler.md
Name: mc_frame_scheduler

Overview:
- Store-and-forward frame sequencer in front of the MC FFT→MULT→IFFT pipeline.
- The MC pipeline has no backpressure and needs 256 back-to-back samples per frame. This block absorbs a bursty valid/ready source into a one-frame buffer, then launches each frame contiguously into MC.
- It tracks frames in flight via MC out_valid beats, bounds concurrency, and flags protocol errors.

Parameters:
- N, 256: samples per frame; power of two, matches the MC FFT size.
- DW, 16: sample width (x, delta real/img), signed Q format passed through untouched.
- MAX_INFLIGHT, 2: maximum frames launched but not yet fully returned by MC; range 1..3.
- TIMEOUT, 4096: idle-cycle limit for the watchdog (optional feature only).

Ports:
- clk  in  1  clock, shared with MC.
- rst  in  1  synchronous active-high reset. Integrator drives MC rst_n = ~rst.
- s_valid  in  1  upstream sample valid.
- s_ready  out  1  high when a beat can be accepted.
- s_x_real  in  DW  signal sample.
- s_delta_real  in  DW  delta coefficient, real part.
- s_delta_img  in  DW  delta coefficient, imaginary part.
- mc_in_valid  out  1  drives MC in_valid.
- mc_x_real  out  DW  drives MC x_real.
- mc_delta_real  out  DW  drives MC delta_real.
- mc_delta_img  out  DW  drives MC delta_img.
- mc_out_valid  in  1  MC out_valid.
- frame_done  out  1  one-cycle pulse on the Nth returned beat of a frame.
- inflight  out  2  frames currently in flight.
- frames_done  out  16  count of completed frames, wraps at 65535→0.
- err_spurious  out  1  sticky: mc_out_valid seen while inflight==0.

Behaviour:
- Reset values: all outputs 0; s_ready=0 during reset and 1 in the first cycle after it; state FILL; all pointers and counters 0.
- Buffer: N entries × 3·DW bits, synchronous write and synchronous read.
- FSM states are FILL, WAIT and LAUNCH.
- FILL:
  - s_ready=1. Each s_valid&s_ready edge writes buffer[wr_ptr] and increments wr_ptr.
  - When beat N-1 is accepted, wr_ptr wraps to 0 and the FSM goes to WAIT.
  - Gaps in s_valid are allowed.
- WAIT:
  - s_ready=0.
  - If inflight<MAX_INFLIGHT (evaluated with this cycle's decrement applied), go to LAUNCH with rd_ptr=0. Otherwise hold.
- LAUNCH:
  - s_ready=0. Read one entry per cycle.
  - mc_in_valid and mc_* are registered, one cycle behind rd_ptr.
  - After issuing beat N-1, return to FILL.
- Launch timing:
  - Last input accepted at edge T.
  - mc_in_valid is first high after edge T+2 when not blocked.
  - It then stays high exactly N consecutive cycles. mc_* data are 0 whenever mc_in_valid=0.
- inflight accounting:
  - Increments on the edge that issues beat 0 of a frame.
  - Decrements on the edge that counts returned beat N-1.
  - If both occur on the same edge, inflight is unchanged.
  - Never exceeds MAX_INFLIGHT.
- Return counter:
  - out_cnt increments on mc_out_valid while inflight>0 and wraps N-1→0.
  - On the wrap, pulse frame_done and increment frames_done.
- Spurious beat: mc_out_valid with inflight==0 sets err_spurious; out_cnt is not advanced. The flag clears only on rst.
- Reset mid-frame (FILL or LAUNCH): the partial frame is discarded and mc_in_valid drops on the reset edge. The integrator resets MC simultaneously.

Optional Feature:
- Macro: MC_SCHED_WATCHDOG_EN.
- Defined:
  - Adds output err_timeout (sticky) and a 16-bit idle counter.
  - The counter runs while inflight>0 and mc_out_valid=0, and clears on any mc_out_valid or when inflight==0.
  - Reaching TIMEOUT sets err_timeout, forces inflight=0 and out_cnt=0, and returns the FSM to FILL if it was in WAIT.
- Undefined: no port, no counter; behaviour is otherwise identical.

Decomposition:
- Shared package mc_pkg:
  - constants MC_N=256 and MC_DW=16;
  - state enum {FILL, WAIT, LAUNCH};
  - log2 helper for pointer widths.
- One natural sub-module: mc_frame_buf, a single-port-write / single-port-read synchronous RAM, N×3·DW, with registered read data.
- The FSM and counters stay in the top.

Test Plan:
- Basic frame:
  - Stimulus: 256 contiguous beats, x=i, delta=(i, -i); MC model latency L=600.
  - Required: mc_in_valid high 256 cycles starting 2 cycles after the last accept, mc_x_real sequence 0..255, inflight=1.
  - After 256 out beats: frame_done single pulse, frames_done=1, inflight=0.
- Bursty input: s_valid toggled 1-0-1 randomly at 50% → mc_in_valid is still a single unbroken 256-cycle burst with in-order data.
- Concurrency limit:
  - Stimulus: MAX_INFLIGHT=2, 3 frames back-to-back, MC latency 2000.
  - Required: third frame holds in WAIT with s_ready=0 and launches on the cycle frame 1 returns beat 255; inflight never exceeds 2.
- Simultaneous events: a launch of beat 0 and a return of beat 255 on the same edge → inflight stays 1, frame_done=1.
- Spurious beat: mc_out_valid pulse after reset with no frame launched → err_spurious=1 and stays set; frames_done=0.
- Reset mid-LAUNCH and watchdog:
  - Stimulus: rst asserted at beat 100 of a launch.
  - Required: mc_in_valid=0 on the reset edge, inflight=0, s_ready=1 one cycle after rst deasserts.
  - With MC_SCHED_WATCHDOG_EN and TIMEOUT=64: a launch with no returns → err_timeout after 64 idle cycles, inflight=0.
